// File: rtl/bp_be_fe_queue_ckpt.sv
// Checkpointing instruction queue between the FE queue interface and issue.
// Three pointers (write, speculative read, commit) each carry an extra wrap
// bit so full/empty and the occupancy differences fall out of plain
// subtraction. Entries between commit and read pointers stay resident, which
// lets a rollback replay them without refetching.
module bp_be_fe_queue_ckpt #(
    parameter  int width_p      = 128,
    parameter  int els_p        = 16,
    parameter  int cmt_width_p  = 2,
    localparam int ptr_width_lp = $clog2(els_p) + 1,
    localparam int cnt_width_lp = $clog2(els_p + 1),
    localparam int deq_width_lp = $clog2(cmt_width_p + 1),
    localparam int idx_width_lp = $clog2(els_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    enq_v_i,
    input  logic [width_p-1:0]      enq_data_i,
    output logic                    enq_ready_o,
    output logic                    iss_v_o,
    output logic [width_p-1:0]      iss_data_o,
    input  logic                    iss_yumi_i,
    input  logic                    clr_i,
    input  logic                    roll_i,
    input  logic                    deq_v_i,
    input  logic [deq_width_lp-1:0] deq_cnt_i,
    output logic [cnt_width_lp-1:0] issued_cnt_o,
    output logic [cnt_width_lp-1:0] free_cnt_o,
    output logic                    err_o
);

    logic [width_p-1:0]      mem [els_p];
    logic [els_p-1:0]        wr_en;

    logic [ptr_width_lp-1:0] wptr_reg, wptr_next;
    logic [ptr_width_lp-1:0] rptr_reg, rptr_next;
    logic [ptr_width_lp-1:0] cptr_reg, cptr_next;
    logic                    err_reg, err_next;
    logic [cnt_width_lp-1:0] issued_cnt_reg, issued_cnt_next;
    logic [cnt_width_lp-1:0] free_cnt_reg, free_cnt_next;

    logic                    full;
    logic                    iss_v;
    logic                    enq_fire;
    logic                    iss_fire;
    logic [ptr_width_lp-1:0] issued_span;
    logic [ptr_width_lp-1:0] deq_req;
    logic [ptr_width_lp-1:0] deq_amt;
    logic                    deq_err;
    logic                    yumi_err;

    // Full is measured against the commit pointer: issued-but-uncommitted
    // entries still occupy storage because a rollback may need them.
    assign full        = (wptr_reg[idx_width_lp-1:0] == cptr_reg[idx_width_lp-1:0])
                       && (wptr_reg[idx_width_lp] != cptr_reg[idx_width_lp]);
    assign iss_v       = (rptr_reg != wptr_reg);
    assign enq_ready_o = ~full & ~clr_i;
    assign enq_fire    = enq_v_i & enq_ready_o;
    assign iss_fire    = iss_yumi_i & iss_v;
    assign yumi_err    = iss_yumi_i & ~iss_v;

    assign iss_v_o      = iss_v;
    assign iss_data_o   = mem[rptr_reg[idx_width_lp-1:0]];
    assign issued_cnt_o = issued_cnt_reg;
    assign free_cnt_o   = free_cnt_reg;
    assign err_o        = err_reg;

    assign issued_span = rptr_reg - cptr_reg;
    assign deq_req     = ptr_width_lp'(deq_cnt_i);

    // One storage register per entry; only the slot under the write pointer
    // captures the payload on an accepted enqueue.
    generate
        for (genvar gi = 0; gi < els_p; gi++) begin : g_entry
            logic [width_p-1:0] entry_reg;

            assign wr_en[gi] = enq_fire
                && (wptr_reg[idx_width_lp-1:0] == idx_width_lp'(gi));
            assign mem[gi]   = entry_reg;

            // Payload capture; storage is deliberately left unreset.
            always_ff @(posedge clk_i) begin
                if (wr_en[gi]) begin
                    entry_reg <= enq_data_i;
                end
            end
        end
    endgenerate

    // Commit amount: a zero request is a no-op and an over-request saturates
    // to the issued span; both are flagged as protocol errors.
    always_comb begin
        deq_amt = '0;
        deq_err = 1'b0;
        if (deq_v_i) begin
            if (deq_req == '0) begin
                deq_err = 1'b1;
            end else if (deq_req > issued_span) begin
                deq_amt = issued_span;
                deq_err = 1'b1;
            end else begin
                deq_amt = deq_req;
            end
        end
    end

    // Next-state pointers: clear beats rollback beats normal operation.
    always_comb begin
        wptr_next = wptr_reg;
        rptr_next = rptr_reg;
        cptr_next = cptr_reg;
        err_next  = err_reg;
        if (clr_i) begin
            wptr_next = wptr_reg;
            rptr_next = wptr_reg;
            cptr_next = wptr_reg;
        end else begin
            cptr_next = cptr_reg + deq_amt;
            if (roll_i) begin
                rptr_next = cptr_next;
            end else if (iss_fire) begin
                rptr_next = rptr_reg + 1'b1;
            end
            if (enq_fire) begin
                wptr_next = wptr_reg + 1'b1;
            end
            err_next = err_reg | deq_err | yumi_err;
        end
        issued_cnt_next = cnt_width_lp'(rptr_next - cptr_next);
        free_cnt_next   = cnt_width_lp'(els_p) - cnt_width_lp'(wptr_next - cptr_next);
    end

    // Pointer, error and occupancy registers; occupancy is computed from the
    // next-state pointers so it describes the queue after each edge.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_reg       <= '0;
            rptr_reg       <= '0;
            cptr_reg       <= '0;
            err_reg        <= 1'b0;
            issued_cnt_reg <= '0;
            free_cnt_reg   <= cnt_width_lp'(els_p);
        end else begin
            wptr_reg       <= wptr_next;
            rptr_reg       <= rptr_next;
            cptr_reg       <= cptr_next;
            err_reg        <= err_next;
            issued_cnt_reg <= issued_cnt_next;
            free_cnt_reg   <= free_cnt_next;
        end
    end

endmodule

// File: tb/tb_bp_be_fe_queue_ckpt.sv
// Scoreboard bench for bp_be_fe_queue_ckpt. The reference model keeps the
// resident entries (oldest uncommitted first) in a queue plus a count of how
// many of them have been issued; every cycle the driver pushes the expected
// outputs for that cycle and the monitor compares them at the falling edge.
module tb_bp_be_fe_queue_ckpt;

    localparam int W   = 128;
    localparam int ELS = 16;

    typedef struct {
        logic         enq_ready;
        logic         iss_v;
        logic [W-1:0] iss_data;
        int           issued;
        int           free;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n_i;
    logic         enq_v_i;
    logic [W-1:0] enq_data_i;
    logic         enq_ready_o;
    logic         iss_v_o;
    logic [W-1:0] iss_data_o;
    logic         iss_yumi_i;
    logic         clr_i;
    logic         roll_i;
    logic         deq_v_i;
    logic [1:0]   deq_cnt_i;
    logic [4:0]   issued_cnt_o;
    logic [4:0]   free_cnt_o;
    logic         err_o;

    bp_be_fe_queue_ckpt #(.width_p(W), .els_p(ELS), .cmt_width_p(2)) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n_i),
        .enq_v_i      (enq_v_i),
        .enq_data_i   (enq_data_i),
        .enq_ready_o  (enq_ready_o),
        .iss_v_o      (iss_v_o),
        .iss_data_o   (iss_data_o),
        .iss_yumi_i   (iss_yumi_i),
        .clr_i        (clr_i),
        .roll_i       (roll_i),
        .deq_v_i      (deq_v_i),
        .deq_cnt_i    (deq_cnt_i),
        .issued_cnt_o (issued_cnt_o),
        .free_cnt_o   (free_cnt_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int tests    = 0;
    int failures = 0;
    int txn      = 0;

    exp_t         sb[$];
    logic [W-1:0] model_q[$];
    int           model_iss = 0;
    logic         model_err = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s txn %0d: got %h expected %h", name, txn, act, exp);
        end
    endtask

    // Monitor: compare whatever expectation the driver queued this cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                txn++;
                chk("enq_ready", W'(enq_ready_o), W'(e.enq_ready));
                chk("iss_v", W'(iss_v_o), W'(e.iss_v));
                if (e.iss_v) chk("iss_data", iss_data_o, e.iss_data);
                chk("issued_cnt", W'(issued_cnt_o), W'(e.issued));
                chk("free_cnt", W'(free_cnt_o), W'(e.free));
                chk("err", W'(err_o), W'(e.err));
                $display("[TB] txn %0d iss_v=%0d issued=%0d free=%0d err=%0d",
                         txn, iss_v_o, issued_cnt_o, free_cnt_o, err_o);
            end
        end
    end

    function automatic exp_t reset_exp();
        exp_t e;
        e.enq_ready = 1'b1;
        e.iss_v     = 1'b0;
        e.iss_data  = '0;
        e.issued    = 0;
        e.free      = ELS;
        e.err       = 1'b0;
        return e;
    endfunction

    task automatic idle_inputs();
        enq_v_i    = 1'b0;
        enq_data_i = '0;
        iss_yumi_i = 1'b0;
        clr_i      = 1'b0;
        roll_i     = 1'b0;
        deq_v_i    = 1'b0;
        deq_cnt_i  = '0;
    endtask

    function automatic logic [W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock of stimulus: drive, queue expectation, advance the model.
    task automatic cycle(input bit enq, input logic [W-1:0] d, input bit yumi,
                         input bit clr, input bit roll, input bit dv, input int dc);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        enq_v_i    = enq;
        enq_data_i = d;
        iss_yumi_i = yumi;
        clr_i      = clr;
        roll_i     = roll;
        deq_v_i    = dv;
        deq_cnt_i  = 2'(dc);

        e.iss_v     = (model_iss < model_q.size());
        e.iss_data  = e.iss_v ? model_q[model_iss] : '0;
        e.enq_ready = (model_q.size() < ELS) && !clr;
        e.issued    = model_iss;
        e.free      = ELS - model_q.size();
        e.err       = model_err;
        sb.push_back(e);

        if (clr) begin
            model_q.delete();
            model_iss = 0;
        end else begin
            if (dv) begin
                n = dc;
                if (n == 0) model_err = 1'b1;
                else if (n > model_iss) begin
                    model_err = 1'b1;
                    n = model_iss;
                end
                repeat (n) void'(model_q.pop_front());
                model_iss -= n;
            end
            if (yumi && !e.iss_v) model_err = 1'b1;
            if (roll) model_iss = 0;
            else if (yumi && e.iss_v) model_iss++;
            if (enq && e.enq_ready) model_q.push_back(d);
        end
    endtask

    task automatic idle();
        cycle(0, '0, 0, 0, 0, 0, 0);
    endtask

    // Reset asserted between edges; outputs must revert before the next edge.
    task automatic mid_reset();
        @(posedge clk);
        #2;
        idle_inputs();
        reset_n_i = 1'b0;
        sb.push_back(reset_exp());
        model_q.delete();
        model_iss = 0;
        model_err = 1'b0;
        @(posedge clk);
        #1;
        reset_n_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b, c;
        bit enq, yumi, clr, roll, dv;
        int dc;

        idle_inputs();
        reset_n_i = 1'b0;
        sb.push_back(reset_exp());
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n_i = 1'b1;

        // Fill to full, then a rejected 17th enqueue.
        for (int i = 0; i < ELS + 1; i++) cycle(1, rnd_data(), 0, 0, 0, 0, 0);
        idle();
        cycle(0, '0, 0, 1, 0, 0, 0);

        // Replay after rollback.
        a = rnd_data(); b = rnd_data(); c = rnd_data();
        cycle(1, a, 0, 0, 0, 0, 0);
        cycle(1, b, 0, 0, 0, 0, 0);
        cycle(1, c, 0, 0, 0, 0, 0);
        cycle(0, '0, 1, 0, 0, 0, 0);
        cycle(0, '0, 1, 0, 0, 0, 0);
        cycle(0, '0, 0, 0, 1, 0, 0);
        idle();

        // Commit two with rollback in the same cycle.
        for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0, 0, 0, 0);
        cycle(0, '0, 0, 0, 1, 1, 2);
        idle();

        // Clear with simultaneous enqueue.
        cycle(0, '0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, rnd_data(), 0, 0, 0, 0, 0);
        cycle(1, rnd_data(), 0, 1, 0, 0, 0);
        idle();

        // Wrap: enqueue/issue/commit every cycle, pointers wrap twice.
        for (int i = 0; i < 40; i++)
            cycle(1, rnd_data(), model_iss < model_q.size(), 0, 0, model_iss > 0, 1);
        idle();

        // Randomized legal traffic.
        for (int i = 0; i < 600; i++) begin
            enq  = ($urandom_range(0, 9) < 7);
            yumi = (model_iss < model_q.size()) && ($urandom_range(0, 9) < 6);
            clr  = ($urandom_range(0, 99) < 3);
            roll = ($urandom_range(0, 99) < 5);
            dv   = (model_iss > 0) && ($urandom_range(0, 9) < 4) && !clr;
            dc   = dv ? $urandom_range(1, (model_iss < 2) ? model_iss : 2) : 0;
            if (clr) yumi = 0;
            cycle(enq, rnd_data(), yumi, clr, roll, dv, dc);
        end
        idle();

        // Over-commit error, then asynchronous reset mid-cycle.
        cycle(0, '0, 0, 1, 0, 0, 0);
        cycle(1, rnd_data(), 0, 0, 0, 0, 0);
        cycle(0, '0, 1, 0, 0, 0, 0);
        cycle(0, '0, 0, 0, 0, 1, 2);
        idle();
        mid_reset();
        idle();

        // Yumi on an empty queue alongside an enqueue.
        cycle(1, rnd_data(), 1, 0, 0, 0, 0);
        idle();
        mid_reset();
        idle();
        idle();

        repeat (3) @(posedge clk);
        chk("scoreboard_drain", W'(sb.size()), W'(0));
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
